// File: rtl/display_digit_scanner.sv
// Time-multiplexed scanner for common-anode seven-segment digits: holds a hex word,
// steps one digit per refresh slot, and drives nibble plus active-low select lines.
module display_digit_scanner #(
  parameter int n_digits      = 8,
  parameter int refresh_width = 16,
  parameter int dead_cycles   = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*n_digits-1:0]   data,
  input  logic                    blank_leading_zeros,
  output logic [3:0]              digit,
  output logic [n_digits-1:0]     digit_select_n,
  output logic [2:0]              slot_index
);

  localparam logic [2:0]               last_index = 3'(n_digits - 1);
  localparam logic [refresh_width-1:0] dead_limit = refresh_width'(dead_cycles);

  logic [4*n_digits-1:0]   shadow;
  logic [refresh_width-1:0] count;
  logic [2:0]              index;
  logic                    count_wrap;
  logic [2:0]              index_next;

  logic [3:0]              nibbles [8];
  logic [7:0]              tail_zero;
  logic                    in_dead;
  logic                    suppress;
  logic [n_digits-1:0]     select_n_next;

  // Unused upper slots read as zero so the scan logic can always use a full 8-entry view.
  for (genvar g = 0; g < 8; g++) begin : g_nib
    if (g < n_digits) begin : g_used
      assign nibbles[g] = shadow[4*g +: 4];
    end else begin : g_unused
      assign nibbles[g] = 4'd0;
    end
  end

  // Shadow register: last word handed over by the parser.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= data;
    end
  end

  // Slot state: refresh counter plus the digit index it paces.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      index <= '0;
    end else begin
      count <= count + 1'b1;
      index <= index_next;
    end
  end

  always_comb begin
    count_wrap = &count;
    index_next = index;
    if (count_wrap) begin
      index_next = (index == last_index) ? 3'd0 : index + 3'd1;
    end
  end

  // tail_zero[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    tail_zero = '0;
    for (int i = 7; i >= 0; i--) begin
      zero_run     = zero_run & (nibbles[i] == 4'd0);
      tail_zero[i] = zero_run;
    end
  end

  always_comb begin
    in_dead  = (count < dead_limit);
    suppress = blank_leading_zeros && (index != 3'd0) && tail_zero[index];
    if (in_dead || suppress) begin
      select_n_next = '1;
    end else begin
      select_n_next = ~(n_digits'(1) << index);
    end
  end

  // Outputs are registered so the decoder and digit drivers see glitch-free lines.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digit          <= 4'd0;
      slot_index     <= 3'd0;
      digit_select_n <= '1;
    end else begin
      digit          <= nibbles[index];
      slot_index     <= index;
      digit_select_n <= select_n_next;
    end
  end

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed bench for display_digit_scanner with 4 digits, 16-cycle slots, 2 dead cycles.
module tb_display_digit_scanner;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic        blank_leading_zeros = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  digit_select_n;
  logic [2:0]  slot_index;
  logic [10:0] got;

  int edges  = 0;
  int n_chk  = 0;
  int n_pass = 0;

  display_digit_scanner #(
    .n_digits(4), .refresh_width(4), .dead_cycles(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .data(data),
    .blank_leading_zeros(blank_leading_zeros), .digit(digit),
    .digit_select_n(digit_select_n), .slot_index(slot_index)
  );

  always #5 clock = ~clock;

  assign got = {slot_index, digit, digit_select_n};

  task automatic tick();
    @(posedge clock);
    #1;
    edges++;
  endtask

  // Counter and slot that the most recent edge registered outputs from.
  function automatic int cur_cnt();
    return (edges - 1) % 16;
  endfunction

  function automatic int cur_idx();
    return ((edges - 1) / 16) % 4;
  endfunction

  task automatic goto(input int si, input int ci);
    int n;
    tick();
    n = 1;
    while (!(cur_idx() == si && cur_cnt() == ci) && n < 100) begin
      tick();
      n++;
    end
    if (!(cur_idx() == si && cur_cnt() == ci)) begin
      n_chk++;
      $display("FAIL goto_bound slot=%0d cnt=%0d required slot=%0d cnt=%0d", cur_idx(), cur_cnt(), si, ci);
    end
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    reset_n = 1'b0;
    tick();
    tick();
    exp = {3'd0, 4'h0, 4'hF};
    n_chk++;
    if (got !== exp) $display("FAIL reset_hold got=%h req=%h", got, exp);
    else n_pass++;
    reset_n = 1'b1;
    edges = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = {3'd0, 4'h0, (k <= 2) ? 4'hF : 4'hE};
      n_chk++;
      if (got !== exp) $display("FAIL reset_release edge=%0d got=%h req=%h", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_scan_order();
    logic [3:0]  dtbl [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0]  stbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [10:0] exp;
    blank_leading_zeros = 1'b0;
    data = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int s = 0; s < 4; s++) begin
      goto(s, 1);
      exp = {3'(s), dtbl[s], 4'hF};
      n_chk++;
      if (got !== exp) $display("FAIL scan_dead slot=%0d got=%h req=%h", s, got, exp);
      else n_pass++;
      goto(s, 2);
      exp = {3'(s), dtbl[s], stbl[s]};
      n_chk++;
      if (got !== exp) $display("FAIL scan_lit slot=%0d got=%h req=%h", s, got, exp);
      else n_pass++;
      goto(s, 15);
      n_chk++;
      if (got !== exp) $display("FAIL scan_end slot=%0d got=%h req=%h", s, got, exp);
      else n_pass++;
    end
    tick();
    exp = {3'd0, 4'h4, 4'hF};
    n_chk++;
    if (got !== exp) $display("FAIL scan_wrap got=%h req=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_leading_zeros();
    logic [15:0] words [4] = '{16'h0050, 16'h0500, 16'h0000, 16'h0000};
    logic        blz   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  dtbl  [4][4] = '{'{4'h0, 4'h5, 4'h0, 4'h0},
                                  '{4'h0, 4'h0, 4'h5, 4'h0},
                                  '{4'h0, 4'h0, 4'h0, 4'h0},
                                  '{4'h0, 4'h0, 4'h0, 4'h0}};
    logic [3:0]  stbl  [4][4] = '{'{4'hE, 4'hD, 4'hF, 4'hF},
                                  '{4'hE, 4'hD, 4'hB, 4'hF},
                                  '{4'hE, 4'hF, 4'hF, 4'hF},
                                  '{4'hE, 4'hD, 4'hB, 4'h7}};
    logic [10:0] exp;
    for (int p = 0; p < 4; p++) begin
      blank_leading_zeros = blz[p];
      data = words[p];
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int s = 0; s < 4; s++) begin
        goto(s, 5);
        exp = {3'(s), dtbl[p][s], stbl[p][s]};
        n_chk++;
        if (got !== exp) $display("FAIL lz word=%h blz=%0d slot=%0d got=%h req=%h", words[p], blz[p], s, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_slot_load();
    logic [10:0] exp;
    blank_leading_zeros = 1'b0;
    data = 16'hAAAA;
    load = 1'b1;
    tick();
    load = 1'b0;
    goto(1, 7);
    data = 16'hBBBB;
    load = 1'b1;
    tick();
    load = 1'b0;
    exp = {3'd1, 4'hA, 4'hD};
    n_chk++;
    if (got !== exp) $display("FAIL mid_first_edge got=%h req=%h", got, exp);
    else n_pass++;
    tick();
    exp = {3'd1, 4'hB, 4'hD};
    n_chk++;
    if (got !== exp) $display("FAIL mid_second_edge got=%h req=%h", got, exp);
    else n_pass++;
    goto(1, 15);
    n_chk++;
    if (got !== exp) $display("FAIL mid_slot_end got=%h req=%h", got, exp);
    else n_pass++;
    tick();
    exp = {3'd2, 4'hB, 4'hF};
    n_chk++;
    if (got !== exp) $display("FAIL mid_next_slot got=%h req=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_load_on_advance();
    logic [10:0] exp;
    goto(2, 14);
    data = 16'h9876;
    load = 1'b1;
    tick();
    load = 1'b0;
    exp = {3'd2, 4'hB, 4'hB};
    n_chk++;
    if (got !== exp) $display("FAIL adv_old_slot got=%h req=%h", got, exp);
    else n_pass++;
    tick();
    exp = {3'd3, 4'h9, 4'hF};
    n_chk++;
    if (got !== exp) $display("FAIL adv_first_nibble got=%h req=%h", got, exp);
    else n_pass++;
    goto(3, 2);
    exp = {3'd3, 4'h9, 4'h7};
    n_chk++;
    if (got !== exp) $display("FAIL adv_lit got=%h req=%h", got, exp);
    else n_pass++;
    goto(0, 2);
    exp = {3'd0, 4'h6, 4'hE};
    n_chk++;
    if (got !== exp) $display("FAIL adv_wrap got=%h req=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [3:0]  stbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [10:0] exp;
    blank_leading_zeros = 1'b0;
    goto(2, 9);
    exp = {3'd2, 4'h8, 4'hB};
    n_chk++;
    if (got !== exp) $display("FAIL async_before got=%h req=%h", got, exp);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    exp = {3'd0, 4'h0, 4'hF};
    n_chk++;
    if (got !== exp) $display("FAIL async_immediate got=%h req=%h", got, exp);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    edges = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp = {3'd0, 4'h0, (k <= 2) ? 4'hF : 4'hE};
      n_chk++;
      if (got !== exp) $display("FAIL async_restart edge=%0d got=%h req=%h", k, got, exp);
      else n_pass++;
    end
    for (int s = 1; s < 4; s++) begin
      goto(s, 2);
      exp = {3'(s), 4'h0, stbl[s]};
      n_chk++;
      if (got !== exp) $display("FAIL async_cleared slot=%0d got=%h req=%h", s, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_leading_zeros();
    test_mid_slot_load();
    test_load_on_advance();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
